pipe_stage_skid: RTL and testbench



---
 rtl/pipe_pkg.sv | 40 ++++
 rtl/pipe_stage_skid.sv | 145 ++++++++++++++
 tb/tb_pipe_stage_skid.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the generic inter-stage pipeline register.
package pipe_pkg;

  // Occupancy of a stage: nothing held, main entry only, main plus skid entry.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } stage_state_e;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_TWO   = 2'd2;

  // Generic defaults used when a stage does not override its widths.
  localparam int unsigned DEFAULT_DATA_W  = 96;
  localparam int unsigned DEFAULT_CTRL_W  = 2;
  localparam int unsigned DEFAULT_STALL_W = 16;

  // Widths for the standard stage instances of the core.
  localparam int unsigned IF_ID_DATA_W  = 64;  // pc + instruction
  localparam int unsigned IF_ID_CTRL_W  = 1;
  localparam int unsigned ID_EX_DATA_W  = 96;  // two operands + immediate
  localparam int unsigned ID_EX_CTRL_W  = 8;
  localparam int unsigned EX_MEM_DATA_W = 64;  // ALU result + store data
  localparam int unsigned EX_MEM_CTRL_W = 4;
  localparam int unsigned MEM_WB_DATA_W = 64;  // read data + ALU result
  localparam int unsigned MEM_WB_CTRL_W = 2;   // RegWrite, MemtoReg

  // Number of entries held in a given state.
  function automatic logic [1:0] occ_of(input stage_state_e s);
    case (s)
      EMPTY:   return OCC_EMPTY;
      FULL:    return OCC_ONE;
      SKID:    return OCC_TWO;
      default: return OCC_EMPTY;
    endcase
  endfunction

endpackage

// File: rtl/pipe_stage_skid.sv
// Generic pipeline-stage register: control + data bundles behind a
// valid/ready handshake, optional 2-entry skid buffer, flush-to-bubble and
// a saturating stall counter.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W  = DEFAULT_DATA_W,
  parameter int unsigned CTRL_W  = DEFAULT_CTRL_W,
  parameter bit          SKID_EN = 1'b1,
  parameter int unsigned STALL_W = DEFAULT_STALL_W
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [CTRL_W-1:0]  in_ctrl_i,
  input  logic [DATA_W-1:0]  in_data_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [CTRL_W-1:0]  out_ctrl_o,
  output logic [DATA_W-1:0]  out_data_o,
  output logic [1:0]         occupancy_o,
  output logic [STALL_W-1:0] stall_cnt_o
);

  stage_state_e state_q, state_d;

  logic [CTRL_W-1:0]  main_ctrl_q, skid_ctrl_q;
  logic [DATA_W-1:0]  main_data_q, skid_data_q;
  logic [1:0]         occ_q;
  logic [STALL_W-1:0] stall_q;

  logic accept, emit;
  logic load_main_in, load_main_skid, load_skid;

  assign out_valid_o = (state_q != EMPTY);
  assign emit        = out_valid_o & out_ready_i;
  assign accept      = in_valid_i & in_ready_o & ~flush_i;

  // Upstream ready: registered decode with a skid entry, otherwise the
  // classic pass-through ready that lets a full stage accept while emitting.
  generate
    if (SKID_EN) begin : g_skid_ready
      assign in_ready_o = (state_q != SKID);
    end else begin : g_flow_ready
      assign in_ready_o = ~out_valid_o | out_ready_i;
    end
  endgenerate

  // Next-state and load-enable decode; flush overrides every other event.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush_i) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d      = FULL;
            load_main_in = 1'b1;
          end
        end
        FULL: begin
          if (accept && emit) begin
            load_main_in = 1'b1;
          end else if (emit) begin
            state_d = EMPTY;
          end else if (accept && SKID_EN) begin
            state_d   = SKID;
            load_skid = 1'b1;
          end
        end
        SKID: begin
          if (emit) begin
            state_d        = FULL;
            load_main_skid = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // State and occupancy registers; occupancy follows the next state so both
  // change on the same edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst_i) begin
      state_q <= EMPTY;
      occ_q   <= OCC_EMPTY;
    end else begin
      state_q <= state_d;
      occ_q   <= occ_of(state_d);
    end
  end

  // Main entry: loaded from the input or promoted from the skid entry.
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: the entry registers are reset like control state because the
    // reset values are visible on out_data_o; they are not a memory array.
    if (rst_i) begin
      main_ctrl_q <= '0;
      main_data_q <= '0;
    end else if (load_main_in) begin
      main_ctrl_q <= in_ctrl_i;
      main_data_q <= in_data_i;
    end else if (load_main_skid) begin
      main_ctrl_q <= skid_ctrl_q;
      main_data_q <= skid_data_q;
    end
  end

  // Skid entry: captures the younger entry while downstream is stalled.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
    end else if (load_skid) begin
      skid_ctrl_q <= in_ctrl_i;
      skid_data_q <= in_data_i;
    end
  end

  // Saturating count of cycles where an entry waits on downstream.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_q <= '0;
    end else if (out_valid_o && !out_ready_i && (stall_q != {STALL_W{1'b1}})) begin
      stall_q <= stall_q + STALL_W'(1);
    end
  end

  assign out_ctrl_o  = out_valid_o ? main_ctrl_q : '0;
  assign out_data_o  = main_data_q;
  assign occupancy_o = occ_q;
  assign stall_cnt_o = stall_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: dut 0 with skid buffer, dut 1 without.
module tb_pipe_stage_skid;

  localparam int DW = 96;
  localparam int CW = 2;
  localparam int SW = 4;
  localparam int STALL_MAX = 15;

  typedef struct packed {
    logic [CW-1:0] ctrl;
    logic [DW-1:0] data;
  } item_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [1:0]         in_valid, in_ready, out_valid, out_ready, flush;
  logic [1:0][CW-1:0] in_ctrl, out_ctrl;
  logic [1:0][DW-1:0] in_data, out_data;
  logic [1:0][1:0]    occ;
  logic [1:0][SW-1:0] stall;

  // bench-side drive values for the next step
  logic [1:0]         drv_v, drv_rdy, drv_fl;
  logic [1:0][CW-1:0] drv_ctrl;
  logic [1:0][DW-1:0] drv_data;

  // reference model: held entries in order, count and stall counter
  item_t q0[$];
  item_t q1[$];
  int    cnt_m   [2];
  int    stall_m [2];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .SKID_EN(1'b1), .STALL_W(SW)) u_skid (
    .clk_i(clk), .rst_i(rst), .flush_i(flush[0]),
    .in_valid_i(in_valid[0]), .in_ready_o(in_ready[0]),
    .in_ctrl_i(in_ctrl[0]), .in_data_i(in_data[0]),
    .out_valid_o(out_valid[0]), .out_ready_i(out_ready[0]),
    .out_ctrl_o(out_ctrl[0]), .out_data_o(out_data[0]),
    .occupancy_o(occ[0]), .stall_cnt_o(stall[0])
  );

  pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .SKID_EN(1'b0), .STALL_W(SW)) u_flow (
    .clk_i(clk), .rst_i(rst), .flush_i(flush[1]),
    .in_valid_i(in_valid[1]), .in_ready_o(in_ready[1]),
    .in_ctrl_i(in_ctrl[1]), .in_data_i(in_data[1]),
    .out_valid_o(out_valid[1]), .out_ready_i(out_ready[1]),
    .out_ctrl_o(out_ctrl[1]), .out_data_o(out_data[1]),
    .occupancy_o(occ[1]), .stall_cnt_o(stall[1])
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_in(input int m, input logic v, input logic [CW-1:0] c,
                        input logic [DW-1:0] d, input logic r, input logic f);
    drv_v[m] = v; drv_ctrl[m] = c; drv_data[m] = d; drv_rdy[m] = r; drv_fl[m] = f;
  endtask

  task automatic idle_all();
    drv_v = '0; drv_ctrl = '0; drv_data = '0; drv_rdy = '0; drv_fl = '0;
  endtask

  function automatic logic [DW-1:0] rand_data();
    return {$urandom(), $urandom(), $urandom()};
  endfunction

  // One clock cycle: drive inputs, compare visible state with the model,
  // then advance the model by what the coming edge will do.
  task automatic step();
    @(posedge clk);
    #1;
    in_valid = drv_v; in_ctrl = drv_ctrl; in_data = drv_data;
    out_ready = drv_rdy; flush = drv_fl;
    #1;
    for (int m = 0; m < 2; m++) begin
      logic rdy, acc, emt;
      item_t it;
      rdy = (m == 0) ? (cnt_m[m] < 2) : (cnt_m[m] == 0 || drv_rdy[m]);
      check($sformatf("dut%0d in_ready", m), 128'(in_ready[m]), 128'(rdy));
      check($sformatf("dut%0d occupancy", m), 128'(occ[m]), 128'(cnt_m[m]));
      check($sformatf("dut%0d out_valid", m), 128'(out_valid[m]), 128'(cnt_m[m] > 0));
      check($sformatf("dut%0d stall_cnt", m), 128'(stall[m]), 128'(stall_m[m]));
      acc = drv_v[m] & rdy & ~drv_fl[m];
      emt = (cnt_m[m] > 0) & drv_rdy[m];
      if (cnt_m[m] > 0 && !drv_rdy[m] && stall_m[m] < STALL_MAX) stall_m[m]++;
      it.ctrl = drv_ctrl[m];
      it.data = drv_data[m];
      if (drv_fl[m]) begin
        cnt_m[m] = 0;
        if (m == 0) q0.delete(); else q1.delete();
      end else begin
        if (acc) begin
          if (m == 0) q0.push_back(it); else q1.push_back(it);
        end
        cnt_m[m] = cnt_m[m] + int'(acc) - int'(emt);
      end
    end
  endtask

  // Monitor: on every downstream handshake pop the oldest expected entry.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        for (int m = 0; m < 2; m++) begin
          if (out_valid[m] && out_ready[m]) begin
            item_t exp_it;
            if ((m == 0 && q0.size() == 0) || (m == 1 && q1.size() == 0)) begin
              check($sformatf("dut%0d unexpected emit", m), 128'(1), 128'(0));
            end else begin
              exp_it = (m == 0) ? q0.pop_front() : q1.pop_front();
              check($sformatf("dut%0d out_data", m), 128'(out_data[m]), 128'(exp_it.data));
              check($sformatf("dut%0d out_ctrl", m), 128'(out_ctrl[m]), 128'(exp_it.ctrl));
            end
          end else if (!out_valid[m]) begin
            check($sformatf("dut%0d bubble ctrl", m), 128'(out_ctrl[m]), 128'(0));
          end
        end
      end
    end
  end

  initial begin
    logic [DW-1:0] a_val, b_val, c_val;
    in_valid = '0; in_ctrl = '0; in_data = '0; out_ready = '0; flush = '0;
    idle_all();
    cnt_m   = '{0, 0};
    stall_m = '{0, 0};
    #12 rst = 1'b0;
    for (int m = 0; m < 2; m++) begin
      check($sformatf("dut%0d reset out_data", m), 128'(out_data[m]), 128'(0));
      check($sformatf("dut%0d reset out_ctrl", m), 128'(out_ctrl[m]), 128'(0));
    end
    step();

    // streaming 1..8 at full rate
    for (int i = 1; i <= 8; i++) begin
      idle_all();
      set_in(0, 1'b1, 2'b11, DW'(i), 1'b1, 1'b0);
      step();
    end
    idle_all();
    set_in(0, 1'b0, 2'b00, '0, 1'b1, 1'b0);
    repeat (3) step();

    // back-pressure: A, B held, then drained in order
    a_val = rand_data();
    b_val = rand_data();
    idle_all(); set_in(0, 1'b1, 2'b01, a_val, 1'b0, 1'b0); step();
    idle_all(); set_in(0, 1'b1, 2'b10, b_val, 1'b0, 1'b0); step();
    idle_all(); set_in(0, 1'b1, 2'b11, rand_data(), 1'b0, 1'b0); step();
    idle_all(); set_in(0, 1'b0, 2'b00, '0, 1'b1, 1'b0);
    repeat (4) step();

    // reset asserted mid-cycle with two entries held
    idle_all(); set_in(0, 1'b1, 2'b01, rand_data(), 1'b0, 1'b0); step();
    idle_all(); set_in(0, 1'b1, 2'b10, rand_data(), 1'b0, 1'b0); step();
    idle_all(); step();
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    for (int m = 0; m < 2; m++) begin
      check($sformatf("dut%0d async rst out_valid", m), 128'(out_valid[m]), 128'(0));
      check($sformatf("dut%0d async rst out_ctrl", m), 128'(out_ctrl[m]), 128'(0));
      check($sformatf("dut%0d async rst out_data", m), 128'(out_data[m]), 128'(0));
      check($sformatf("dut%0d async rst in_ready", m), 128'(in_ready[m]), 128'(1));
      check($sformatf("dut%0d async rst occupancy", m), 128'(occ[m]), 128'(0));
      check($sformatf("dut%0d async rst stall", m), 128'(stall[m]), 128'(0));
    end
    q0.delete(); q1.delete();
    cnt_m = '{0, 0}; stall_m = '{0, 0};
    in_valid = '0; in_ctrl = '0; in_data = '0; out_ready = '0; flush = '0;
    idle_all();
    @(negedge clk);
    rst = 1'b0;

    // stall counter saturates at 15 and survives a flush
    idle_all(); set_in(0, 1'b1, 2'b11, rand_data(), 1'b0, 1'b0); step();
    idle_all();
    repeat (20) step();
    idle_all(); set_in(0, 1'b0, 2'b00, '0, 1'b0, 1'b1); step();
    idle_all(); step();
    check("stall held after flush", 128'(stall[0]), 128'(STALL_MAX));

    // flush with two entries held and a simultaneous input C
    a_val = rand_data();
    b_val = rand_data();
    c_val = rand_data();
    idle_all(); set_in(0, 1'b1, 2'b01, a_val, 1'b0, 1'b0); step();
    idle_all(); set_in(0, 1'b1, 2'b10, b_val, 1'b0, 1'b0); step();
    idle_all(); set_in(0, 1'b1, 2'b11, c_val, 1'b0, 1'b1); step();
    idle_all(); set_in(0, 1'b0, 2'b00, '0, 1'b1, 1'b0);
    repeat (4) step();

    // no skid buffer: A held, then B accepted while A leaves
    a_val = rand_data();
    b_val = rand_data();
    idle_all(); set_in(1, 1'b1, 2'b01, a_val, 1'b0, 1'b0); step();
    idle_all(); set_in(1, 1'b1, 2'b10, b_val, 1'b0, 1'b0); step();
    idle_all(); set_in(1, 1'b1, 2'b10, b_val, 1'b1, 1'b0); step();
    idle_all(); set_in(1, 1'b0, 2'b00, '0, 1'b1, 1'b0);
    repeat (3) step();

    // randomized traffic on both instances
    for (int i = 0; i < 400; i++) begin
      for (int m = 0; m < 2; m++) begin
        logic v, r, f;
        v = ($urandom_range(0, 3) != 0);
        r = ($urandom_range(0, 2) != 0);
        f = ($urandom_range(0, 24) == 0);
        if (f) r = 1'b0;
        set_in(m, v, CW'($urandom_range(0, 3)), rand_data(), r, f);
      end
      step();
    end
    idle_all(); drv_rdy = 2'b11;
    repeat (4) step();

    check("dut0 drained", 128'(q0.size()), 128'(0));
    check("dut1 drained", 128'(q1.size()), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
